// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge.
// Qualifies and decodes AHB transfers, hands them to the APB controller
// as a level request, stalls the master until done, and produces the
// two-cycle ERROR response for unmapped or misaligned transfers.
module ahb_slave_if #(
    parameter logic [31:0] BASE0    = 32'h8000_0000,
    parameter logic [31:0] BASE1    = 32'h8400_0000,
    parameter logic [31:0] BASE2    = 32'h8800_0000,
    parameter int unsigned WIN_BITS = 26
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic        Hwrite,
    input  logic [2:0]  Hsize,
    input  logic [31:0] Hwdata,
    input  logic        Hreadyin,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata,
    output logic        req,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic        req_write,
    output logic [2:0]  req_sel,
    input  logic        done,
    input  logic [31:0] Prdata
);

    typedef enum logic [2:0] {StIdle, StData, StWait, StErr1, StErr2} state_e;

    state_e      state_q, state_d;
    logic [2:0]  sel_dec;
    logic        size_bad;
    logic        xfer_bad;
    logic        accept;
    logic        req_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        write_q;
    logic [2:0]  sel_q;

    // Htrans[0] only separates IDLE/BUSY and NONSEQ/SEQ, which are treated alike
    logic unused_trans;
    assign unused_trans = Htrans[0];

    // Window decode: one select per peripheral, compared on the bits above the window
    always_comb begin
        sel_dec = 3'b000;
        if (Haddr[31:WIN_BITS] == BASE0[31:WIN_BITS]) sel_dec[0] = 1'b1;
        if (Haddr[31:WIN_BITS] == BASE1[31:WIN_BITS]) sel_dec[1] = 1'b1;
        if (Haddr[31:WIN_BITS] == BASE2[31:WIN_BITS]) sel_dec[2] = 1'b1;
    end

    // Size / alignment check
    always_comb begin
        size_bad = 1'b0;
        case (Hsize)
            3'b000:  size_bad = 1'b0;
            3'b001:  size_bad = Haddr[0];
            3'b010:  size_bad = |Haddr[1:0];
            default: size_bad = 1'b1;
        endcase
    end

    assign xfer_bad = size_bad | (sel_dec == 3'b000);
    assign accept   = Hreadyin & Hreadyout & Htrans[1] & (state_q == StIdle);

    // Next-state logic and state-decoded bus outputs
    always_comb begin
        state_d   = state_q;
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = xfer_bad ? StErr1 : StData;
            end
            StData: begin
                Hreadyout = 1'b0;
                state_d   = StWait;
            end
            StWait: begin
                Hreadyout = 1'b0;
                if (done) state_d = StIdle;
            end
            StErr1: begin
                Hreadyout = 1'b0;
                Hresp     = 2'b01;
                state_d   = StErr2;
            end
            StErr2: begin
                Hresp   = 2'b01;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge Hclk) begin
        if (Hreset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Request datapath: latch on accept, capture write data in DATA, return read data on done
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            sel_q   <= 3'b000;
            rdata_q <= '0;
        end else begin
            if (accept && !xfer_bad) begin
                addr_q  <= Haddr;
                write_q <= Hwrite;
                sel_q   <= sel_dec;
            end
            if (state_q == StData) begin
                wdata_q <= Hwdata;
                req_q   <= 1'b1;
            end
            // done only counts once the request is actually up
            if (state_q == StWait && done) begin
                req_q <= 1'b0;
                if (!write_q) rdata_q <= Prdata;
            end
        end
    end

    assign req       = req_q;
    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;
    assign req_write = write_q;
    assign req_sel   = sel_q;
    assign Hrdata    = rdata_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Testbench for ahb_slave_if: directed AHB transfers with a small
// transaction-level model checked against the DUT every cycle.
module tb_ahb_slave_if;

    logic        Hclk, Hreset;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic        req;
    logic [31:0] req_addr, req_wdata;
    logic        req_write;
    logic [2:0]  req_sel;
    logic        done;
    logic [31:0] Prdata;

    ahb_slave_if dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwrite    (Hwrite),
        .Hsize     (Hsize),
        .Hwdata    (Hwdata),
        .Hreadyin  (Hreadyin),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .req       (req),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .req_sel   (req_sel),
        .done      (done),
        .Prdata    (Prdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    int total = 0;
    int bad   = 0;

    // Model: an outstanding-transfer flag with its age, and an error countdown
    bit          m_busy;
    int          m_age;
    int          m_err;
    logic [31:0] m_addr, m_wd, m_rd;
    logic        m_wr;
    logic [2:0]  m_sel;

    // Responder and monitor state
    bit          resp_en;
    int          resp_delay;
    int          wcnt;
    logic [31:0] rd_val;
    bit          rdy_at_edge, rdy_prev, req_prev;
    int          low_cnt, err_cnt;
    logic [31:0] rd_at_rise;
    logic [31:0] seen_addr[$];
    logic [31:0] seen_wd[$];
    logic [2:0]  seen_sel[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Map an address to a one-hot select by window index; 0 when unmapped
    function automatic logic [2:0] m_decode(input logic [31:0] a);
        int k;
        if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
        k = int'((a - 32'h8000_0000) >> 26);
        return 3'(1 << k);
    endfunction

    function automatic bit m_bad(input logic [31:0] a, input logic [2:0] sz);
        if (m_decode(a) == 3'b000) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_err = 0;
        m_addr = '0; m_wd = '0; m_rd = '0; m_wr = 1'b0; m_sel = 3'b000;
    endtask

    // Advance the model across one rising edge using the inputs present at that edge
    task automatic model_step();
        if (Hreset) begin
            model_reset();
        end else if (m_err > 0) begin
            m_err--;
        end else if (m_busy) begin
            if (m_age == 0) begin
                m_wd  = Hwdata;
                m_age = 1;
            end else if (done) begin
                m_busy = 0;
                if (!m_wr) m_rd = Prdata;
            end
        end else if (Hreadyin && Htrans[1]) begin
            if (m_bad(Haddr, Hsize)) begin
                m_err = 2;
            end else begin
                m_busy = 1; m_age = 0;
                m_addr = Haddr; m_wr = Hwrite; m_sel = m_decode(Haddr);
            end
        end
    endtask

    task automatic compare();
        chk("hreadyout", 32'(Hreadyout), 32'(!m_busy && m_err != 2));
        chk("hresp", 32'(Hresp), (m_err > 0) ? 32'd1 : 32'd0);
        chk("req", 32'(req), 32'(m_busy && m_age == 1));
        chk("hrdata", Hrdata, m_rd);
        chk("req_addr", req_addr, m_addr);
        chk("req_sel", 32'(req_sel), 32'(m_sel));
        chk("req_write", 32'(req_write), 32'(m_wr));
        chk("req_wdata", req_wdata, m_wd);
        rdy_at_edge = Hreadyout;
        if (!Hreadyout) low_cnt++;
        if (Hresp == 2'b01) err_cnt++;
        if (req && !req_prev) begin
            seen_addr.push_back(req_addr);
            seen_sel.push_back(req_sel);
            seen_wd.push_back(req_wdata);
        end
        if (Hreadyout && !rdy_prev) rd_at_rise = Hrdata;
        req_prev = req;
        rdy_prev = Hreadyout;
    endtask

    // APB side: pulse done after resp_delay cycles of req
    task automatic responder();
        done = 1'b0;
        if (resp_en && req && !Hreset) begin
            wcnt++;
            if (wcnt >= resp_delay) begin
                done   = 1'b1;
                Prdata = rd_val;
                wcnt   = 0;
            end
        end else begin
            wcnt = 0;
        end
    endtask

    task automatic tick();
        @(negedge Hclk);
        compare();
        @(posedge Hclk);
        model_step();
        #1;
        responder();
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!rdy_at_edge && k < 40);
        if (!rdy_at_edge) begin
            total++;
            bad++;
            $display("FAIL %s: got no ready within %0d cycles want ready", name, k);
        end
    endtask

    // Pipelined master: n beats, next address presented during previous data phase
    task automatic ahb_seq(input logic [31:0] a0, input int n, input logic w,
                           input logic [2:0] sz, input int step, input logic [31:0] wd0);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                Htrans = (i == 0) ? 2'b10 : 2'b11;
                Haddr  = a0 + 32'(i * step);
                Hwrite = w;
                Hsize  = sz;
            end else begin
                Htrans = 2'b00;
            end
            if (i > 0) Hwdata = wd0 + 32'(i - 1);
            wait_ready("ahb_ready");
        end
        Htrans = 2'b00;
    endtask

    task automatic clr_mon();
        low_cnt = 0; err_cnt = 0;
        seen_addr.delete(); seen_sel.delete(); seen_wd.delete();
    endtask

    initial begin
        Hreset = 1'b1; Htrans = 2'b00; Haddr = '0; Hwrite = 1'b0; Hsize = 3'b000;
        Hwdata = '0; Hreadyin = 1'b1; done = 1'b0; Prdata = '0;
        resp_en = 1'b0; resp_delay = 1; wcnt = 0; rd_val = '0;
        rdy_prev = 1'b1; req_prev = 1'b0; rd_at_rise = '0;
        model_reset();
        clr_mon();
        repeat (2) @(posedge Hclk);
        #1;
        Hreset = 1'b0;

        // Reset state
        chk("rst_hreadyout", 32'(Hreadyout), 32'd1);
        chk("rst_hresp", 32'(Hresp), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_hrdata", Hrdata, 32'd0);
        chk("rst_req_addr", req_addr, 32'd0);
        tick();

        // Single write, done on the third WAIT cycle
        clr_mon();
        resp_en = 1'b1; resp_delay = 3;
        ahb_seq(32'h8000_0500, 1, 1'b1, 3'b010, 4, 32'h0003_2845);
        chk("wr_low_cycles", 32'(low_cnt), 32'd4);
        chk("wr_err_cycles", 32'(err_cnt), 32'd0);
        chk("wr_req_count", 32'(seen_addr.size()), 32'd1);
        if (seen_addr.size() == 1) begin
            chk("wr_addr", seen_addr[0], 32'h8000_0500);
            chk("wr_sel", 32'(seen_sel[0]), 32'd1);
            chk("wr_wdata", seen_wd[0], 32'h0003_2845);
        end

        // Single read
        clr_mon();
        resp_delay = 2; rd_val = 32'h0005_4280;
        ahb_seq(32'h8400_0704, 1, 1'b0, 3'b010, 4, 32'h0);
        chk("rd_hrdata_at_ready", rd_at_rise, 32'h0005_4280);
        chk("rd_req_count", 32'(seen_sel.size()), 32'd1);
        if (seen_sel.size() == 1) chk("rd_sel", 32'(seen_sel[0]), 32'd2);

        // Unmapped address and misaligned word
        clr_mon();
        ahb_seq(32'h9000_0000, 1, 1'b1, 3'b010, 4, 32'h0);
        chk("err1_resp_cycles", 32'(err_cnt), 32'd2);
        chk("err1_low_cycles", 32'(low_cnt), 32'd1);
        chk("err1_no_req", 32'(seen_addr.size()), 32'd0);
        clr_mon();
        ahb_seq(32'h8800_0002, 1, 1'b1, 3'b010, 4, 32'h0);
        chk("err2_resp_cycles", 32'(err_cnt), 32'd2);
        chk("err2_no_req", 32'(seen_addr.size()), 32'd0);
        clr_mon();
        ahb_seq(32'h8800_0001, 1, 1'b0, 3'b001, 2, 32'h0);
        ahb_seq(32'h8800_0000, 1, 1'b0, 3'b011, 8, 32'h0);
        chk("err_hw_sz_resp_cycles", 32'(err_cnt), 32'd4);

        // Good halfword read at the top of window 2
        clr_mon();
        rd_val = 32'h0000_BEEF;
        ahb_seq(32'h8BFF_FFFE, 1, 1'b0, 3'b001, 2, 32'h0);
        chk("hw_sel", 32'(req_sel), 32'd4);
        chk("hw_hrdata", Hrdata, 32'h0000_BEEF);

        // INCR4 byte write burst
        clr_mon();
        resp_delay = 1;
        ahb_seq(32'h8800_1000, 4, 1'b1, 3'b000, 1, 32'hB000_00A0);
        chk("burst_req_count", 32'(seen_addr.size()), 32'd4);
        chk("burst_low_cycles", 32'(low_cnt), 32'd8);
        if (seen_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("burst_addr", seen_addr[i], 32'h8800_1000 + 32'(i));
                chk("burst_sel", 32'(seen_sel[i]), 32'd4);
                chk("burst_wdata", seen_wd[i], 32'hB000_00A0 + 32'(i));
            end
        end

        // BUSY, IDLE, spurious done, and NONSEQ without Hreadyin
        clr_mon();
        resp_en = 1'b0;
        Haddr = 32'h8000_0000; Hsize = 3'b010; Hwrite = 1'b0;
        Htrans = 2'b01; tick();
        Htrans = 2'b00; done = 1'b1; Prdata = 32'hDEAD_0001; tick();
        Htrans = 2'b10; Hreadyin = 1'b0; tick();
        Htrans = 2'b00; Hreadyin = 1'b1; tick();
        chk("idle_low_cycles", 32'(low_cnt), 32'd0);
        chk("idle_err_cycles", 32'(err_cnt), 32'd0);
        chk("idle_no_req", 32'(seen_addr.size()), 32'd0);
        chk("idle_hrdata_kept", Hrdata, 32'h0000_BEEF);

        // done coinciding with the DATA cycle is ignored
        Htrans = 2'b10; Haddr = 32'h8400_0000; Hwrite = 1'b0; Hsize = 3'b010;
        tick();
        Htrans = 2'b00; done = 1'b1; Prdata = 32'hDEAD_BEEF;
        tick();
        chk("early_done_stall", 32'(Hreadyout), 32'd0);
        chk("early_done_req", 32'(req), 32'd1);
        tick();
        done = 1'b1; Prdata = 32'h1234_5678;
        tick();
        chk("late_done_hrdata", Hrdata, 32'h1234_5678);
        chk("late_done_ready", 32'(Hreadyout), 32'd1);
        tick();

        // Reset while the request is up
        clr_mon();
        Htrans = 2'b10; Haddr = 32'h8000_0010; Hwrite = 1'b1; Hsize = 3'b010;
        tick();
        Htrans = 2'b00; Hwdata = 32'h1111_2222;
        tick();
        tick();
        chk("rst_mid_req_up", 32'(req), 32'd1);
        Hreset = 1'b1;
        tick();
        Hreset = 1'b0;
        chk("rst_mid_req", 32'(req), 32'd0);
        chk("rst_mid_ready", 32'(Hreadyout), 32'd1);
        chk("rst_mid_addr", req_addr, 32'd0);
        chk("rst_mid_sel", 32'(req_sel), 32'd0);
        clr_mon();
        resp_en = 1'b1; resp_delay = 1;
        ahb_seq(32'h8000_0020, 1, 1'b1, 3'b010, 4, 32'hCAFE_0001);
        chk("post_rst_req_count", 32'(seen_addr.size()), 32'd1);
        if (seen_addr.size() == 1) begin
            chk("post_rst_addr", seen_addr[0], 32'h8000_0020);
            chk("post_rst_wdata", seen_wd[0], 32'hCAFE_0001);
        end
        chk("post_rst_low_cycles", 32'(low_cnt), 32'd2);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
